vga_fb_arbiter: RTL and testbench

- Schedules a single-port synchronous framebuffer RAM between two users: display scan-out reads driven by the VGA timing generator, and CPU pixel writes.
- The framebuffer is FB_W x FB_H and is upscaled by 2^SCALE_LOG2 to 640x480. The display needs one read per 2^SCALE_LOG2 pixel clocks; the remaining slots drain a CPU write FIFO or a hardware clear engine.
- Also delays the sync signals so they stay aligned with the fetched RGB.

---
 rtl/vga_fb_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer scheduler: VGA scan-out reads take every 2^SCALE_LOG2-th
// visible pixel slot; the remaining slots serve a fill engine, then a CPU write FIFO.
module vga_fb_arbiter #(
   parameter int FB_W       = 160,
   parameter int FB_H       = 120,
   parameter int SCALE_LOG2 = 2,
   parameter int DATA_W     = 3,
   parameter int ADDR_W     = 15,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [9:0]        pixel_x,
   input  logic [9:0]        pixel_y,
   input  logic              video_on_in,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic              cpu_wr,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_data,
   output logic              cpu_ready,
   input  logic              clear_req,
   input  logic [DATA_W-1:0] clear_color,
   output logic              clear_busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] rgb,
   output logic              hsync,
   output logic              vsync,
   output logic              video_on
);

   localparam int                FB_SIZE   = FB_W * FB_H;
   localparam int                PTR_W     = $clog2(FIFO_DEPTH);
   localparam int                ENTRY_W   = ADDR_W + DATA_W;
   localparam logic [31:0]       FB_SIZE_U = 32'(FB_SIZE);
   localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(FB_SIZE - 1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1'b1);
   localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1'b1);
   localparam logic [PTR_W:0]    CNT_ONE   = (PTR_W + 1)'(1'b1);
   localparam logic [PTR_W:0]    CNT_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } clr_state_t;

   clr_state_t          state_r;
   clr_state_t          state_next_s;

   logic                display_slot_s;
   logic                free_slot_s;
   logic [ADDR_W-1:0]   disp_addr_s;

   logic                clear_start_s;
   logic                clear_write_s;
   logic                clr_last_s;
   logic [ADDR_W-1:0]   clr_addr_r;
   logic [DATA_W-1:0]   clr_color_r;
   logic                clear_busy_r;

   logic [ENTRY_W-1:0]  fifo_mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_r;
   logic [PTR_W-1:0]    rd_ptr_r;
   logic [PTR_W:0]      count_r;
   logic                fifo_full_s;
   logic                fifo_empty_s;
   logic                addr_in_range_s;
   logic                push_s;
   logic                store_s;
   logic                pop_s;
   logic [ENTRY_W-1:0]  fifo_head_s;

   logic [1:0]          tag_r;
   logic [DATA_W-1:0]   pix_r;
   logic [DATA_W-1:0]   rgb_r;
   logic [2:0]          von_r;
   logic [2:0]          hs_r;
   logic [2:0]          vs_r;

   assign display_slot_s = video_on_in && (pixel_x[SCALE_LOG2-1:0] == {SCALE_LOG2{1'b0}});
   assign free_slot_s    = ~display_slot_s;
   assign disp_addr_s    = ADDR_W'(32'(pixel_y >> SCALE_LOG2) * 32'(FB_W)
                                   + 32'(pixel_x >> SCALE_LOG2));

   assign clr_last_s     = (clr_addr_r == CLR_LAST);

   // Readiness tracks fullness only, so a same-cycle pop never admits a push into a full FIFO
   assign fifo_full_s     = (count_r == CNT_FULL);
   assign fifo_empty_s    = (count_r == {(PTR_W + 1){1'b0}});
   assign addr_in_range_s = (32'(cpu_addr) < FB_SIZE_U);
   assign cpu_ready       = rst_n & ~fifo_full_s;
   assign push_s          = cpu_wr & cpu_ready;
   assign store_s         = push_s & addr_in_range_s;
   assign pop_s           = free_slot_s & (state_r == ST_IDLE) & ~fifo_empty_s;
   assign fifo_head_s     = fifo_mem_r[rd_ptr_r];

   // Clear FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Clear FSM next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (clear_req) begin
               state_next_s = ST_CLEAR;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            if (clear_write_s && clr_last_s) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_CLEAR;
            end
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // Clear FSM outputs
   always_comb begin
      clear_start_s = 1'b0;
      clear_write_s = 1'b0;
      case (state_r)
         ST_IDLE:  clear_start_s = clear_req;
         ST_CLEAR: clear_write_s = free_slot_s;
         default: begin
            clear_start_s = 1'b0;
            clear_write_s = 1'b0;
         end
      endcase
   end

   // Fill address walker and latched fill colour
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_addr_r   <= {ADDR_W{1'b0}};
         clr_color_r  <= {DATA_W{1'b0}};
         clear_busy_r <= 1'b0;
      end else begin
         if (clear_start_s) begin
            clr_addr_r  <= {ADDR_W{1'b0}};
            clr_color_r <= clear_color;
         end else if (clear_write_s) begin
            clr_addr_r <= clr_addr_r + ADDR_ONE;
         end
         clear_busy_r <= (state_next_s == ST_CLEAR);
      end
   end

   assign clear_busy = clear_busy_r;

   // CPU write FIFO; out-of-range entries are acknowledged but never stored
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {(PTR_W + 1){1'b0}};
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem_r[i] <= {ENTRY_W{1'b0}};
         end
      end else begin
         if (store_s) begin
            fifo_mem_r[wr_ptr_r] <= {cpu_addr, cpu_data};
            wr_ptr_r             <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({store_s, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // RAM port: display read > fill write > FIFO write > idle (address holds)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_addr  <= {ADDR_W{1'b0}};
         mem_wdata <= {DATA_W{1'b0}};
         mem_we    <= 1'b0;
      end else begin
         if (display_slot_s) begin
            mem_addr <= disp_addr_s;
            mem_we   <= 1'b0;
         end else if (clear_write_s) begin
            mem_addr  <= clr_addr_r;
            mem_wdata <= clr_color_r;
            mem_we    <= 1'b1;
         end else if (pop_s) begin
            mem_addr  <= fifo_head_s[ENTRY_W-1:DATA_W];
            mem_wdata <= fifo_head_s[DATA_W-1:0];
            mem_we    <= 1'b1;
         end else begin
            mem_we <= 1'b0;
         end
      end
   end

   // Read-return tag, pixel hold register and 3-stage sync alignment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_r <= 2'b00;
         pix_r <= {DATA_W{1'b0}};
         rgb_r <= {DATA_W{1'b0}};
         von_r <= 3'b000;
         hs_r  <= 3'b111;
         vs_r  <= 3'b111;
      end else begin
         tag_r <= {tag_r[0], display_slot_s};
         if (tag_r[1]) begin
            pix_r <= mem_rdata;
         end
         rgb_r <= von_r[1] ? (tag_r[1] ? mem_rdata : pix_r) : {DATA_W{1'b0}};
         von_r <= {von_r[1:0], video_on_in};
         hs_r  <= {hs_r[1:0], hsync_in};
         vs_r  <= {vs_r[1:0], vsync_in};
      end
   end

   assign rgb      = rgb_r;
   assign video_on = von_r[2];
   assign hsync    = hs_r[2];
   assign vsync    = vs_r[2];

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: a per-cycle vector table for slot arbitration plus
// directed sequences for scan-out latency, FIFO contention, clear and reset.
`timescale 1ns/1ps
module tb_vga_fb_arbiter;

   logic        clk;
   logic        rst_n;
   logic [9:0]  pixel_x;
   logic [9:0]  pixel_y;
   logic        video_on_in;
   logic        hsync_in;
   logic        vsync_in;
   logic        cpu_wr;
   logic [14:0] cpu_addr;
   logic [2:0]  cpu_data;
   logic        cpu_ready;
   logic        clear_req;
   logic [2:0]  clear_color;
   logic        clear_busy;
   logic [14:0] mem_addr;
   logic [2:0]  mem_wdata;
   logic        mem_we;
   logic [2:0]  mem_rdata;
   logic [2:0]  rgb;
   logic        hsync;
   logic        vsync;
   logic        video_on;

   int checks = 0;
   int errors = 0;
   logic [17:0] wlog [$];

   typedef struct {
      logic        von;
      logic [9:0]  px;
      logic [9:0]  py;
      logic        wr;
      logic [14:0] caddr;
      logic [2:0]  cdata;
      logic        exp_we;
      logic [14:0] exp_addr;
      logic [2:0]  exp_wdata;
   } vec_t;

   vga_fb_arbiter #(
      .FB_W(160), .FB_H(120), .SCALE_LOG2(2), .DATA_W(3), .ADDR_W(15), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .video_on_in(video_on_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_ready(cpu_ready),
      .clear_req(clear_req), .clear_color(clear_color), .clear_busy(clear_busy),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
      .rgb(rgb), .hsync(hsync), .vsync(vsync), .video_on(video_on)
   );

   initial begin
      clk = 1'b0;
      forever #20 clk = ~clk;
   end

   // Read-only RAM model: two known locations, everything else reads zero
   always @(posedge clk) begin
      case (mem_addr)
         15'd162: mem_rdata <= 3'b110;
         15'd163: mem_rdata <= 3'b011;
         default: mem_rdata <= 3'b000;
      endcase
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      pixel_x     = 10'd0;
      pixel_y     = 10'd0;
      video_on_in = 1'b0;
      hsync_in    = 1'b1;
      vsync_in    = 1'b1;
      cpu_wr      = 1'b0;
      cpu_addr    = 15'd0;
      cpu_data    = 3'd0;
      clear_req   = 1'b0;
      clear_color = 3'd0;
   endtask

   // One clock: log RAM writes and confirm a display slot never turns into a write
   task automatic step();
      logic disp;
      disp = video_on_in && (pixel_x[1:0] == 2'b00);
      @(posedge clk);
      #1;
      if (mem_we === 1'b1) wlog.push_back({mem_addr, mem_wdata});
      if (disp) chk("disp_slot_no_write", 32'(mem_we), 32'd0);
   endtask

   initial begin
      vec_t        vecs [13];
      logic        hs_hist [12];
      logic        vs_hist [12];
      logic        von_hist [12];
      bit          seen [19200];
      logic [17:0] entry;
      logic [14:0] a;
      logic [2:0]  exp_rgb;
      int          m;
      int          n;
      int          bad_addr;
      int          bad_data;

      vecs[0]  = '{1'b0, 10'd0,  10'd0, 1'b1, 15'd100,   3'b101, 1'b0, 15'd0,   3'b000};
      vecs[1]  = '{1'b0, 10'd0,  10'd0, 1'b0, 15'd0,     3'b000, 1'b1, 15'd100, 3'b101};
      vecs[2]  = '{1'b0, 10'd0,  10'd0, 1'b0, 15'd0,     3'b000, 1'b0, 15'd100, 3'b101};
      vecs[3]  = '{1'b1, 10'd8,  10'd4, 1'b0, 15'd0,     3'b000, 1'b0, 15'd162, 3'b101};
      vecs[4]  = '{1'b1, 10'd9,  10'd4, 1'b1, 15'd5,     3'b001, 1'b0, 15'd162, 3'b101};
      vecs[5]  = '{1'b1, 10'd10, 10'd4, 1'b1, 15'd6,     3'b010, 1'b1, 15'd5,   3'b001};
      vecs[6]  = '{1'b1, 10'd11, 10'd4, 1'b1, 15'd7,     3'b011, 1'b1, 15'd6,   3'b010};
      vecs[7]  = '{1'b1, 10'd12, 10'd4, 1'b1, 15'd8,     3'b100, 1'b0, 15'd163, 3'b010};
      vecs[8]  = '{1'b1, 10'd13, 10'd4, 1'b0, 15'd0,     3'b000, 1'b1, 15'd7,   3'b011};
      vecs[9]  = '{1'b1, 10'd14, 10'd4, 1'b0, 15'd0,     3'b000, 1'b1, 15'd8,   3'b100};
      vecs[10] = '{1'b1, 10'd15, 10'd4, 1'b0, 15'd0,     3'b000, 1'b0, 15'd8,   3'b100};
      vecs[11] = '{1'b0, 10'd0,  10'd0, 1'b1, 15'd19200, 3'b111, 1'b0, 15'd8,   3'b100};
      vecs[12] = '{1'b0, 10'd0,  10'd0, 1'b0, 15'd0,     3'b000, 1'b0, 15'd8,   3'b100};

      // Reset held with random inputs
      idle_inputs();
      rst_n = 1'b0;
      for (int i = 0; i < 5; i++) begin
         pixel_x     = 10'($urandom_range(0, 639));
         pixel_y     = 10'($urandom_range(0, 479));
         video_on_in = 1'($urandom_range(0, 1));
         hsync_in    = 1'($urandom_range(0, 1));
         vsync_in    = 1'($urandom_range(0, 1));
         cpu_wr      = 1'($urandom_range(0, 1));
         cpu_addr    = 15'($urandom_range(0, 32767));
         cpu_data    = 3'($urandom_range(0, 7));
         clear_req   = 1'($urandom_range(0, 1));
         clear_color = 3'($urandom_range(0, 7));
         @(posedge clk);
         #1;
         chk("rst_mem_we", 32'(mem_we), 32'd0);
         chk("rst_mem_addr", 32'(mem_addr), 32'd0);
         chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
         chk("rst_rgb", 32'(rgb), 32'd0);
         chk("rst_hsync", 32'(hsync), 32'd1);
         chk("rst_vsync", 32'(vsync), 32'd1);
         chk("rst_video_on", 32'(video_on), 32'd0);
         chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
         chk("rst_clear_busy", 32'(clear_busy), 32'd0);
      end
      idle_inputs();
      rst_n = 1'b1;
      #1;
      chk("rel_cpu_ready", 32'(cpu_ready), 32'd1);
      repeat (3) step();

      // Cycle vector table: blanking write, display fetch address, slot sharing, out-of-range push
      for (int i = 0; i < 13; i++) begin
         video_on_in = vecs[i].von;
         pixel_x     = vecs[i].px;
         pixel_y     = vecs[i].py;
         cpu_wr      = vecs[i].wr;
         cpu_addr    = vecs[i].caddr;
         cpu_data    = vecs[i].cdata;
         #1;
         chk($sformatf("tbl%0d_ready", i), 32'(cpu_ready), 32'd1);
         step();
         chk($sformatf("tbl%0d_we", i), 32'(mem_we), 32'(vecs[i].exp_we));
         chk($sformatf("tbl%0d_addr", i), 32'(mem_addr), 32'(vecs[i].exp_addr));
         chk($sformatf("tbl%0d_wdata", i), 32'(mem_wdata), 32'(vecs[i].exp_wdata));
      end
      idle_inputs();
      repeat (4) step();

      // Scan-out: fetch at x=8 and x=12, RGB and syncs appear exactly 3 cycles later
      for (int k = 0; k < 12; k++) begin
         video_on_in = (k < 8);
         pixel_x     = (k < 8) ? 10'(8 + k) : 10'd0;
         pixel_y     = (k < 8) ? 10'd4 : 10'd0;
         hsync_in    = !(k == 2 || k == 3);
         vsync_in    = (k != 5);
         hs_hist[k]  = hsync_in;
         vs_hist[k]  = vsync_in;
         von_hist[k] = video_on_in;
         step();
         m = k + 1;
         if (m >= 3 && m <= 6) exp_rgb = 3'b110;
         else if (m >= 7 && m <= 10) exp_rgb = 3'b011;
         else exp_rgb = 3'b000;
         chk($sformatf("scan%0d_rgb", m), 32'(rgb), 32'(exp_rgb));
         if (k >= 2) begin
            chk($sformatf("scan%0d_hsync", m), 32'(hsync), 32'(hs_hist[k-2]));
            chk($sformatf("scan%0d_vsync", m), 32'(vsync), 32'(vs_hist[k-2]));
            chk($sformatf("scan%0d_von", m), 32'(video_on), 32'(von_hist[k-2]));
         end else begin
            chk($sformatf("scan%0d_hsync", m), 32'(hsync), 32'd1);
            chk($sformatf("scan%0d_von", m), 32'(video_on), 32'd0);
         end
      end
      idle_inputs();
      repeat (4) step();

      // Contention: six back-to-back pushes during active video drain in order
      wlog.delete();
      for (int k = 0; k < 16; k++) begin
         video_on_in = 1'b1;
         pixel_x     = 10'(k);
         pixel_y     = 10'd8;
         cpu_wr      = (k < 6);
         cpu_addr    = 15'(300 + k);
         cpu_data    = 3'(k + 1);
         #1;
         chk($sformatf("cont%0d_ready", k), 32'(cpu_ready), 32'd1);
         step();
      end
      idle_inputs();
      step();
      chk("cont_nwrites", 32'(wlog.size()), 32'd6);
      for (int j = 0; j < 6; j++) begin
         if (j < wlog.size())
            chk($sformatf("cont_order%0d", j), 32'(wlog[j]), 32'({15'(300 + j), 3'(j + 1)}));
      end

      // Clear in blanking; FIFO fills behind it and drains after the last fill write
      wlog.delete();
      clear_req   = 1'b1;
      clear_color = 3'b010;
      step();
      chk("clr_busy_start", 32'(clear_busy), 32'd1);
      for (int k = 0; k < 6; k++) begin
         clear_req   = (k == 0);
         clear_color = (k == 0) ? 3'b111 : 3'b010;
         cpu_wr      = 1'b1;
         cpu_addr    = 15'(200 + k);
         cpu_data    = 3'(k + 1);
         #1;
         chk($sformatf("clr_ready%0d", k), 32'(cpu_ready), (k < 4) ? 32'd1 : 32'd0);
         step();
      end
      idle_inputs();
      n = 0;
      while (clear_busy && n < 20000) begin
         step();
         n++;
      end
      chk("clr_done_in_time", 32'(clear_busy), 32'd0);
      repeat (8) step();
      chk("clr_total_writes", 32'(wlog.size()), 32'd19204);
      bad_addr = 0;
      bad_data = 0;
      for (int i = 0; i < 19200 && i < wlog.size(); i++) begin
         entry = wlog[i];
         a     = entry[17:3];
         if (a >= 15'd19200) bad_addr++;
         else if (seen[a]) bad_addr++;
         else seen[a] = 1'b1;
         if (entry[2:0] != 3'b010) bad_data++;
      end
      chk("clr_addr_cover", 32'(bad_addr), 32'd0);
      chk("clr_data", 32'(bad_data), 32'd0);
      for (int j = 0; j < 4; j++) begin
         if (19200 + j < wlog.size())
            chk($sformatf("clr_fifo%0d", j), 32'(wlog[19200 + j]), 32'({15'(200 + j), 3'(j + 1)}));
      end

      // Reset in the middle of a clear while a pixel is on screen
      clear_req   = 1'b1;
      clear_color = 3'b101;
      step();
      clear_req   = 1'b0;
      video_on_in = 1'b1;
      pixel_x     = 10'd8;
      pixel_y     = 10'd4;
      repeat (6) step();
      pixel_x = 10'd9;
      step();
      chk("mid_pre_rgb", 32'(rgb), 32'd6);
      chk("mid_pre_busy", 32'(clear_busy), 32'd1);
      chk("mid_pre_we", 32'(mem_we), 32'd1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(clear_busy), 32'd0);
      chk("mid_rst_we", 32'(mem_we), 32'd0);
      chk("mid_rst_rgb", 32'(rgb), 32'd0);
      chk("mid_rst_von", 32'(video_on), 32'd0);
      chk("mid_rst_ready", 32'(cpu_ready), 32'd0);
      idle_inputs();
      step();
      step();
      rst_n = 1'b1;
      wlog.delete();
      repeat (10) step();
      chk("mid_post_writes", 32'(wlog.size()), 32'd0);
      chk("mid_post_busy", 32'(clear_busy), 32'd0);
      chk("mid_post_ready", 32'(cpu_ready), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
